// File: rtl/eq_config_pkg.sv
// Shared constants, FSM state types and byte-lane helper for the equalizer config slave.
package eq_config_pkg;

  localparam int unsigned OFS_CTRL   = 0;
  localparam int unsigned OFS_STATUS = 4;
  localparam int unsigned OFS_GAIN0  = 8;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [15:0] UNITY_GAIN  = 16'h4000;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [15:0] merge16(input logic [15:0] old_val,
                                          input logic [15:0] new_val,
                                          input logic [1:0]  strb);
    merge16 = old_val;
    if (strb[0]) merge16[7:0]  = new_val[7:0];
    if (strb[1]) merge16[15:8] = new_val[15:8];
  endfunction

endpackage

// File: rtl/eq_config_regfile.sv
// Register storage, byte-lane writes and read mux for the equalizer config slave.
// EQ_CONFIG_SHADOW_EN: gains/enable reach the datapath only on a CTRL commit.
module eq_config_regfile
  import eq_config_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned NUM_BANDS = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [31:0]              i_wr_data,
  input  logic [3:0]               i_wr_strb,
  output logic                     o_wr_err,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic [31:0]              o_rd_data,
  output logic                     o_rd_err,
  input  logic [31:0]              i_status,
  output logic                     o_eq_enable,
  output logic [16*NUM_BANDS-1:0]  o_eq_gain,
  output logic                     o_cfg_update
);

  localparam int unsigned IDX_W    = ADDR_W - 2;
  localparam int unsigned LAST_IDX = OFS_GAIN0 / 4 + NUM_BANDS - 1;

  logic [IDX_W-1:0]                w_wr_idx, w_rd_idx;
  logic                            r_ctrl_en, w_nxt_ctrl_en, w_commit;
  logic [NUM_BANDS-1:0][15:0]      r_gain, w_nxt_gain;
  logic                            r_cfg_update;
  logic                            w_unused_bits;

  assign w_wr_idx = i_wr_addr[ADDR_W-1:2];
  assign w_rd_idx = i_rd_addr[ADDR_W-1:2];
  assign o_wr_err = (w_wr_idx > IDX_W'(LAST_IDX));

  always_comb begin
    w_nxt_ctrl_en = r_ctrl_en;
    w_nxt_gain    = r_gain;
    w_commit      = 1'b0;
    if (i_wr_en) begin
      if (w_wr_idx == IDX_W'(OFS_CTRL / 4) && i_wr_strb[0]) begin
        w_nxt_ctrl_en = i_wr_data[0];
        w_commit      = i_wr_data[1];
      end
      for (int unsigned k = 0; k < NUM_BANDS; k++) begin
        if (w_wr_idx == IDX_W'(OFS_GAIN0 / 4 + k))
          w_nxt_gain[k] = merge16(r_gain[k], i_wr_data[15:0], i_wr_strb[1:0]);
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_err  = 1'b0;
    if (w_rd_idx == IDX_W'(OFS_CTRL / 4))
      o_rd_data = {31'b0, r_ctrl_en};
    else if (w_rd_idx == IDX_W'(OFS_STATUS / 4))
      o_rd_data = i_status;
    else if (w_rd_idx > IDX_W'(LAST_IDX))
      o_rd_err = 1'b1;
    else
      for (int unsigned k = 0; k < NUM_BANDS; k++)
        if (w_rd_idx == IDX_W'(OFS_GAIN0 / 4 + k)) o_rd_data = {16'h0000, r_gain[k]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl_en <= 1'b0;
      r_gain    <= {NUM_BANDS{UNITY_GAIN}};
    end else begin
      r_ctrl_en <= w_nxt_ctrl_en;
      r_gain    <= w_nxt_gain;
    end
  end

`ifdef EQ_CONFIG_SHADOW_EN
  logic                       r_commit, r_live_en, w_nxt_live_en;
  logic [NUM_BANDS-1:0][15:0] r_live_gain, w_nxt_live_gain;

  // Commit copies the already-updated shadow set, so it lands one cycle after the CTRL write.
  always_comb begin
    w_nxt_live_en   = r_commit ? r_ctrl_en : r_live_en;
    w_nxt_live_gain = r_commit ? r_gain    : r_live_gain;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_commit     <= 1'b0;
      r_live_en    <= 1'b0;
      r_live_gain  <= {NUM_BANDS{UNITY_GAIN}};
      r_cfg_update <= 1'b0;
    end else begin
      r_commit     <= w_commit;
      r_live_en    <= w_nxt_live_en;
      r_live_gain  <= w_nxt_live_gain;
      r_cfg_update <= ({w_nxt_live_en, w_nxt_live_gain} != {r_live_en, r_live_gain});
    end
  end

  assign o_eq_enable   = r_live_en;
  assign o_eq_gain     = r_live_gain;
  assign w_unused_bits = ^{i_wr_data[31:16], i_wr_strb[3:2], i_wr_addr[1:0], i_rd_addr[1:0]};
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cfg_update <= 1'b0;
    else       r_cfg_update <= ({w_nxt_ctrl_en, w_nxt_gain} != {r_ctrl_en, r_gain});
  end

  assign o_eq_enable   = r_ctrl_en;
  assign o_eq_gain     = r_gain;
  assign w_unused_bits = ^{i_wr_data[31:16], i_wr_strb[3:2], i_wr_addr[1:0], i_rd_addr[1:0], w_commit};
`endif

  assign o_cfg_update = r_cfg_update;

endmodule

// File: rtl/eq_config_axil_slave.sv
// AXI4-Lite slave exposing equalizer CTRL/STATUS/GAIN registers; handshake FSMs live here.
// Optional EQ_CONFIG_SHADOW_EN (see eq_config_regfile) shadows gains until a CTRL commit.
module eq_config_axil_slave
  import eq_config_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_BANDS          = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          eq_enable,
  output logic [16*NUM_BANDS-1:0]       eq_gain,
  output logic                          cfg_update,
  input  logic [31:0]                   eq_status
);

  wr_state_t                     r_wstate, w_wstate_nxt;
  rd_state_t                     r_rstate, w_rstate_nxt;
  logic                          r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]                   r_wdata;
  logic [3:0]                    r_wstrb;
  logic [1:0]                    r_bresp;
  logic                          r_arready, r_rvalid;
  logic [31:0]                   r_rdata;
  logic [1:0]                    r_rresp;
  logic                          w_aw_hs, w_w_hs, w_ar_hs, w_wr_en, w_wr_err, w_rd_err;
  logic [31:0]                   w_rd_data;

  assign w_aw_hs = S_AXI_AWVALID && r_awready;
  assign w_w_hs  = S_AXI_WVALID  && r_wready;
  assign w_ar_hs = S_AXI_ARVALID && r_arready;
  assign w_wr_en = (r_wstate == W_IDLE) && r_aw_held && r_w_held;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_rstate_nxt = r_rstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_en) w_wstate_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // READY flags are registered so they come up on the first edge after reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (r_wstate == W_IDLE) begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= S_AXI_AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      r_awready <= !(r_aw_held || w_aw_hs);
      r_wready  <= !(r_w_held || w_w_hs);
      if (w_wr_en) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (S_AXI_BREADY) begin
      r_bvalid  <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (r_rstate == R_IDLE) begin
      r_arready <= !w_ar_hs;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_err ? 32'h0 : w_rd_data;
        r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end else if (S_AXI_RREADY) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end
  end

  eq_config_regfile #(
    .ADDR_W    (C_S_AXI_ADDR_WIDTH),
    .NUM_BANDS (NUM_BANDS)
  ) u_regfile (
    .i_clk        (ACLK),
    .i_rst        (ARESET),
    .i_wr_en      (w_wr_en),
    .i_wr_addr    (r_awaddr),
    .i_wr_data    (r_wdata),
    .i_wr_strb    (r_wstrb),
    .o_wr_err     (w_wr_err),
    .i_rd_addr    (S_AXI_ARADDR),
    .o_rd_data    (w_rd_data),
    .o_rd_err     (w_rd_err),
    .i_status     (eq_status),
    .o_eq_enable  (eq_enable),
    .o_eq_gain    (eq_gain),
    .o_cfg_update (cfg_update)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_eq_config_axil_slave.sv
// Directed bench for eq_config_axil_slave: table of AXI-Lite accesses plus handshake/reset corner sequences.
module tb_eq_config_axil_slave;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic         clk, rst;
  logic [5:0]   awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         eq_enable, cfg_update;
  logic [127:0] eq_gain;
  logic [31:0]  eq_status;

  int checks = 0;
  int errors = 0;
  int cfg_cnt = 0;
  int b_cnt = 0;

  eq_config_axil_slave #(.C_S_AXI_ADDR_WIDTH(6), .NUM_BANDS(8)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .eq_enable(eq_enable), .eq_gain(eq_gain), .cfg_update(cfg_update), .eq_status(eq_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_update === 1'b1) cfg_cnt++;
    if (bvalid === 1'b1 && bready === 1'b1) b_cnt++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int  n;
    logic aw_hs, w_hs;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1; n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    while (!bvalid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    resp = bresp;
    if (!bvalid) begin
      timeout("write_bvalid");
      resp = 2'bxx;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int  n;
    logic hs;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      hs = arready;
      @(posedge clk); #1; n++;
      if (hs) arvalid = 1'b0;
    end
    while (!rvalid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    d = rdata; resp = rresp;
    if (!rvalid) begin
      timeout("read_rvalid");
      d = 'x;
    end
    arvalid = 1'b0;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] d;
  logic [1:0]  r;
  logic [127:0] exp_gain;
  int          n, c0, b0;

  initial begin
    rst = 1'b1; eq_status = 32'hDEAD_BEEF;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    vecs.push_back('{1'b1, 6'h08, 32'h0000_0001, 4'hF, 32'h0, OK});
    vecs.push_back('{1'b1, 6'h0C, 32'h0000_0002, 4'hF, 32'h0, OK});
    vecs.push_back('{1'b1, 6'h10, 32'h0000_0003, 4'hF, 32'h0, OK});
    vecs.push_back('{1'b1, 6'h14, 32'h0000_0004, 4'hF, 32'h0, OK});
    vecs.push_back('{1'b0, 6'h08, 32'h0, 4'h0, 32'h0000_0001, OK});
    vecs.push_back('{1'b0, 6'h0C, 32'h0, 4'h0, 32'h0000_0002, OK});
    vecs.push_back('{1'b0, 6'h10, 32'h0, 4'h0, 32'h0000_0003, OK});
    vecs.push_back('{1'b0, 6'h14, 32'h0, 4'h0, 32'h0000_0004, OK});
    vecs.push_back('{1'b0, 6'h00, 32'h0, 4'h0, 32'h0000_0000, OK});
    vecs.push_back('{1'b1, 6'h00, 32'h0000_0003, 4'hF, 32'h0, OK});
    vecs.push_back('{1'b0, 6'h00, 32'h0, 4'h0, 32'h0000_0001, OK});
    vecs.push_back('{1'b0, 6'h04, 32'h0, 4'h0, 32'hDEAD_BEEF, OK});
    vecs.push_back('{1'b1, 6'h04, 32'h1234_5678, 4'hF, 32'h0, OK});
    vecs.push_back('{1'b0, 6'h04, 32'h0, 4'h0, 32'hDEAD_BEEF, OK});
    vecs.push_back('{1'b1, 6'h1C, 32'hFFFF_FFFF, 4'h1, 32'h0, OK});
    vecs.push_back('{1'b0, 6'h1C, 32'h0, 4'h0, 32'h0000_40FF, OK});
    vecs.push_back('{1'b1, 6'h20, 32'hFFFF_FFFF, 4'h2, 32'h0, OK});
    vecs.push_back('{1'b0, 6'h20, 32'h0, 4'h0, 32'h0000_FF00, OK});
    vecs.push_back('{1'b1, 6'h24, 32'hFFFF_FFFF, 4'h0, 32'h0, OK});
    vecs.push_back('{1'b0, 6'h24, 32'h0, 4'h0, 32'h0000_4000, OK});
    vecs.push_back('{1'b1, 6'h3C, 32'h0000_0000, 4'hF, 32'h0, ERR});
    vecs.push_back('{1'b0, 6'h3C, 32'h0, 4'h0, 32'h0000_0000, ERR});
    vecs.push_back('{1'b1, 6'h28, 32'h0000_0000, 4'hF, 32'h0, ERR});
    vecs.push_back('{1'b0, 6'h28, 32'h0, 4'h0, 32'h0000_0000, ERR});
    vecs.push_back('{1'b0, 6'h0B, 32'h0, 4'h0, 32'h0000_0001, OK});
    vecs.push_back('{1'b1, 6'h11, 32'hFFFF_0005, 4'hF, 32'h0, OK});
    vecs.push_back('{1'b0, 6'h10, 32'h0, 4'h0, 32'h0000_0005, OK});

    // Reset state while ARESET held
    cycles(2);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_resp_rdata", {bresp, rresp, rdata}, 0);
    chk("rst_cfg_update", cfg_update, 0);
    chk("rst_eq_enable", eq_enable, 0);
    chk("rst_eq_gain", eq_gain, {8{16'h4000}});
    rst = 1'b0;
    cycles(1);
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), r, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), r, vecs[i].exp_resp);
      end
    end

`ifdef EQ_CONFIG_SHADOW_EN
    exp_gain = {16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
`else
    exp_gain = {16'h4000, 16'hFF00, 16'h40FF, 16'h4000, 16'h0004, 16'h0005, 16'h0002, 16'h0001};
`endif
    chk("table_eq_gain", eq_gain, exp_gain);
    chk("table_eq_enable", eq_enable, 1);

    // W channel arrives three cycles before AW
    b0 = b_cnt;
    wdata = 32'h0000_ABCD; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    cycles(1);
    wvalid = 1'b0;
    chk("w_first_wready_drop", wready, 0);
    cycles(2);
    chk("w_first_no_bvalid", bvalid, 0);
    awaddr = 6'h08; awvalid = 1'b1;
    cycles(1);
    awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin cycles(1); n++; end
    if (!bvalid) timeout("w_first_bvalid");
    chk("w_first_bresp", bresp, OK);
    cycles(3);
    bready = 1'b0;
    chk("w_first_single_b", b_cnt - b0, 1);
    axi_read(6'h08, d, r);
    chk("w_first_gain0", d, 32'h0000_ABCD);

    // Read and write of GAIN4 resolving on the same edge return the old value
    awaddr = 6'h18; wdata = 32'h0000_1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    cycles(1);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h18; arvalid = 1'b1; rready = 1'b1;
    cycles(1);
    arvalid = 1'b0;
    chk("rw_same_rvalid", rvalid, 1);
    chk("rw_same_rdata_old", rdata, 32'h0000_4000);
    chk("rw_same_bvalid", bvalid, 1);
    cycles(2);
    rready = 1'b0; bready = 1'b0;
    axi_read(6'h18, d, r);
    chk("rw_same_rdata_new", d, 32'h0000_1234);

`ifdef EQ_CONFIG_SHADOW_EN
    c0 = cfg_cnt;
    axi_write(6'h10, 32'h0000_1000, 4'hF, r);
    cycles(3);
    chk("shadow_gain2_held", eq_gain[47:32], 16'h0003);
    chk("shadow_no_pulse", cfg_cnt - c0, 0);
    axi_write(6'h00, 32'h0000_0003, 4'hF, r);
    cycles(3);
    chk("shadow_gain2_commit", eq_gain[47:32], 16'h1000);
    chk("shadow_enable", eq_enable, 1);
    chk("shadow_one_pulse", cfg_cnt - c0, 1);
`else
    c0 = cfg_cnt;
    axi_write(6'h18, 32'h0000_1234, 4'hF, r);
    cycles(2);
    chk("cfg_same_value_no_pulse", cfg_cnt - c0, 0);
    axi_write(6'h18, 32'h0000_2222, 4'hF, r);
    cycles(2);
    chk("cfg_change_one_pulse", cfg_cnt - c0, 1);
    chk("cfg_gain4_direct", eq_gain[79:64], 16'h2222);
`endif

    // Reset while a write response is stalled
    awaddr = 6'h08; wdata = 32'h0000_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    cycles(1);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin cycles(1); n++; end
    if (!bvalid) timeout("rst_flight_bvalid");
    #2 rst = 1'b1;
    #1;
    chk("rst_flight_bvalid_drop", bvalid, 0);
    chk("rst_flight_awready", awready, 0);
    chk("rst_flight_gain", eq_gain, {8{16'h4000}});
    cycles(1);
    rst = 1'b0;
    cycles(1);
    chk("rst_flight_readies", {awready, wready, arready, bvalid}, 4'b1110);
    axi_read(6'h08, d, r);
    chk("rst_flight_gain0_read", d, 32'h0000_4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/eq_config_axil_slave.md
EQ_CONFIG_AXIL_SLAVE -- requirements
Module: eq_config_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte-address width of the AXI4-Lite slave port.
REQ-002 SHALL have parameter NUM_BANDS, default 8, number of equalizer band-gain registers (1..13).
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-006 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
REQ-007 S_AXI_WDATA  in  32  write data.
REQ-008 S_AXI_WSTRB  in  4  byte-lane write enables.
REQ-009 S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
REQ-010 S_AXI_BRESP  out  2  write response (OKAY=00, SLVERR=10).
REQ-011 S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
REQ-012 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
REQ-013 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
REQ-014 S_AXI_RDATA  out  32  read data.
REQ-015 S_AXI_RRESP  out  2  read response.
REQ-016 S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
REQ-017 eq_enable  out  1  CTRL[0], equalizer enable.
REQ-018 eq_gain  out  16*NUM_BANDS  band gains, band k in bits [16k+15:16k], signed Q2.14.
REQ-019 cfg_update  out  1  one-cycle pulse when eq_gain/eq_enable change.
REQ-020 eq_status  in  32  status word from datapath, read-only via STATUS.

Function
REQ-021 Word map (addr[1:0] ignored): 0x00 CTRL (RW; bit0 enable, bit1 commit, self-clearing, reads 0), 0x04 STATUS (RO), 0x08+4k GAIN k (RW, bits[15:0]; bits[31:16] read 0).
REQ-022 Write FSM W_IDLE -> W_RESP -> W_IDLE; AW and W accepted in either order or same cycle, each latched independently, AWREADY/WREADY deasserted once its channel is captured; register update occurs the cycle both are held; BVALID asserts the next cycle.
REQ-023 BVALID SHALL hold until BREADY; no new AW/W accepted while BVALID=1 (one outstanding write).
REQ-024 WSTRB SHALL gate each byte lane; WSTRB=0 SHALL update nothing but still respond OKAY.
REQ-025 Write to STATUS ignored, OKAY; address beyond last GAIN: ignored, BRESP=SLVERR.
REQ-026 Read FSM R_IDLE -> R_DATA: ARREADY=1 in R_IDLE; RVALID/RDATA/RRESP registered one cycle after AR handshake, held until RREADY; out-of-range read: RDATA=0, RRESP=SLVERR.
REQ-027 Simultaneous read and write to same register: read returns the pre-write value.
REQ-028 cfg_update SHALL pulse one cycle after any effective change of eq_enable or eq_gain (per REQ-033 when shadowing compiled in).

Reset
REQ-029 ARESET=1 SHALL immediately force: all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, CTRL 0, all GAIN registers 16'h4000 (unity), cfg_update 0, FSMs to IDLE; a transaction in flight is dropped without response.
REQ-030 After deassertion, AWREADY/WREADY/ARREADY SHALL assert on the first rising edge.

Configuration
REQ-031 Macro EQ_CONFIG_SHADOW_EN selects shadowed gains.
REQ-032 Without it: GAIN writes drive eq_gain directly on the update cycle; CTRL[1] has no effect.
REQ-033 With it: GAIN writes land in shadow registers (read back via AXI); eq_gain/eq_enable update only on a CTRL write with bit1=1, one cycle after that write.

Structure
REQ-034 Package eq_config_pkg SHALL hold address offsets, RESP_OKAY/RESP_SLVERR, unity-gain constant and the write/read FSM state typedefs.
REQ-035 One sub-module eq_config_regfile (storage, byte-lane write, read mux); AXI handshake FSMs stay in the top.

Verification
REQ-036 Write 1,2,3,4 to 0x08,0x0C,0x10,0x14 then read back -> RDATA 1,2,3,4, all RESP OKAY.
REQ-037 W presented 3 cycles before AW with 0xABCD to 0x08 -> single BVALID after AW, GAIN0=0xABCD.
REQ-038 Write 0xFFFF_FFFF with WSTRB=0b0001 to GAIN1 (0x4000) -> reads 0x0000_40FF.
REQ-039 Read/write 0x3C (NUM_BANDS=8) -> RRESP/BRESP=SLVERR, RDATA=0, no register change.
REQ-040 EQ_CONFIG_SHADOW_EN: write GAIN2=0x1000 -> eq_gain unchanged; write CTRL=0x3 -> eq_gain band2=0x1000, eq_enable=1, one cfg_update pulse.
REQ-041 Assert ARESET while BVALID=1 and BREADY=0 -> BVALID drops immediately, gains return to 0x4000.
